// File: rtl/mips_cpu_muldiv_seq.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide, UNROLL bits per edge.
// Optional `MULDIV_EARLY_TERM_EN: multiplies finish early once the remaining multiplier is zero.
module mips_cpu_muldiv_seq #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int K  = WIDTH / UNROLL;
  localparam int CW = $clog2(K + 1);

`ifdef MULDIV_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          count, count_nxt;
  logic [WIDTH-1:0]       hi_nxt, lo_nxt;
  logic                   busy_nxt, done_nxt;

  // Shared datapath: acc is the product for multiplies and the partial remainder for divides.
  logic [2*WIDTH-1:0]     acc, acc_nxt;
  logic [2*WIDTH-1:0]     mcand, mcand_nxt;
  logic [WIDTH-1:0]       mplier, mplier_nxt;
  logic                   is_div, neg_res, neg_rem, div0;
  logic                   div_carry;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    a_neg, b_neg, launch, skip;
  logic [WIDTH-1:0]        a_mag, b_mag;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign a_s    = a;
  assign b_s    = b;
  assign a_neg  = ~op[0] && (a_s < 0);
  assign b_neg  = ~op[0] && (b_s < 0);
  assign a_mag  = cneg(a, a_neg);
  assign b_mag  = cneg(b, b_neg);
  assign launch = (state == IDLE) && start;
  assign skip   = EARLY_TERM && !is_div && (mplier == '0);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    hi_nxt     = hi;
    lo_nxt     = lo;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    div_carry  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = RUN;
          count_nxt  = CW'(K);
          busy_nxt   = 1'b1;
          mplier_nxt = b_mag;
          mcand_nxt  = {{WIDTH{1'b0}}, a_mag};
          acc_nxt    = op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
        end else begin
          if (mthi) hi_nxt = wdata;
          if (mtlo) lo_nxt = wdata;
        end
      end
      RUN: begin
        if (skip) begin
          state_nxt = FIX;
          count_nxt = '0;
        end else begin
          for (int i = 0; i < UNROLL; i++) begin
            if (is_div) begin
              // Bit shifted out of the top keeps the W+1-bit remainder exact.
              div_carry = acc_nxt[2*WIDTH-1];
              acc_nxt   = acc_nxt << 1;
              if (div_carry || (acc_nxt[2*WIDTH-1:WIDTH] >= mplier)) begin
                acc_nxt[2*WIDTH-1:WIDTH] = acc_nxt[2*WIDTH-1:WIDTH] - mplier;
                acc_nxt[0]               = 1'b1;
              end
            end else begin
              if (mplier_nxt[0]) acc_nxt = acc_nxt + mcand_nxt;
              mcand_nxt  = mcand_nxt << 1;
              mplier_nxt = mplier_nxt >> 1;
            end
          end
          count_nxt = count - 1'b1;
          if (count == CW'(1)) state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        if (is_div) begin
          lo_nxt = div0 ? '1 : cneg(acc[WIDTH-1:0], neg_res);
          hi_nxt = cneg(acc[2*WIDTH-1:WIDTH], neg_rem);
        end else begin
          {hi_nxt, lo_nxt} = cneg2(acc, neg_res);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (clk_enable) begin
      state <= state_nxt;
      count <= count_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Datapath and operand flags carry no reset; they are reloaded on every launch.
  always_ff @(posedge clk) begin
    if (clk_enable) begin
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      if (launch) begin
        is_div  <= op[1];
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        div0    <= (b == '0);
      end
    end
  end

endmodule
